// File: rtl/redmule_mx_wr_scheduler.sv
// Sequences one MX output tile (FP8 value beats + packed shared exponents) onto a single store port.
// Optional performance counters are enabled by defining REDMULE_MX_WR_SCHED_PERF_EN.
module redmule_mx_wr_scheduler #(
    parameter int DATAW_ALIGN = 512,
    parameter int EXP_W       = 8,
    parameter int CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       tile_beats_i,
    input  logic                   val_valid_i,
    output logic                   val_ready_o,
    input  logic [DATAW_ALIGN-1:0] val_data_i,
    input  logic                   exp_valid_i,
    output logic                   exp_ready_o,
    input  logic [EXP_W-1:0]       exp_data_i,
    output logic                   wr_valid_o,
    input  logic                   wr_ready_i,
    output logic [DATAW_ALIGN-1:0] wr_data_o,
    output logic                   wr_sel_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [31:0]            perf_stall_o,
    output logic [31:0]            perf_exp_o
);

    localparam int EXP_PER_WORD = DATAW_ALIGN / EXP_W;
    localparam int PACK_W       = $clog2(EXP_PER_WORD);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]             state_reg;
    logic [1:0]             state_next;
    logic [CNT_W-1:0]       beats_reg;
    logic [CNT_W-1:0]       val_cnt_reg;
    logic [CNT_W-1:0]       exp_cnt_reg;
    logic [PACK_W-1:0]      pack_cnt_reg;
    logic                   pend_reg;
    logic                   wr_valid_reg;
    logic                   wr_sel_reg;
    logic [DATAW_ALIGN-1:0] wr_data_reg;
    logic [DATAW_ALIGN-1:0] pack_word;

    logic is_idle;
    logic is_run;
    logic is_drain;
    logic ld;
    logic start_acc;
    logic val_hs;
    logic exp_hs;
    logic word_ld;
    logic pack_wrap;
    logic flush;
    logic tile_done;

    assign is_idle  = (state_reg == ST_IDLE);
    assign is_run   = (state_reg == ST_RUN);
    assign is_drain = (state_reg == ST_DRAIN);

    // The output register can take a new beat when empty or being drained this cycle.
    assign ld        = !wr_valid_reg || wr_ready_i;
    assign start_acc = is_idle && start_i;

    assign val_ready_o = is_run && ld && !pend_reg && (val_cnt_reg < beats_reg);
    assign exp_ready_o = is_run && !pend_reg && (exp_cnt_reg < beats_reg);
    assign val_hs      = val_valid_i && val_ready_o;
    assign exp_hs      = exp_valid_i && exp_ready_o;

    assign word_ld   = is_run && ld && pend_reg;
    assign pack_wrap = exp_hs && (pack_cnt_reg == PACK_W'(EXP_PER_WORD - 1));
    // Last exponent landed mid-word: flush the partial word (upper lanes are already zero).
    assign flush     = is_run && !pend_reg && (exp_cnt_reg == beats_reg) && (pack_cnt_reg != '0);
    assign tile_done = is_run && (val_cnt_reg == beats_reg) && (exp_cnt_reg == beats_reg)
                       && !pend_reg && (pack_cnt_reg == '0);

    assign busy_o     = !is_idle;
    assign done_o     = is_drain && ld;
    assign wr_valid_o = wr_valid_reg;
    assign wr_sel_o   = wr_sel_reg;
    assign wr_data_o  = wr_data_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_i)   state_next = ST_RUN;
            ST_RUN:   if (tile_done) state_next = ST_DRAIN;
            ST_DRAIN: if (ld)        state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            beats_reg    <= '0;
            val_cnt_reg  <= '0;
            exp_cnt_reg  <= '0;
            pack_cnt_reg <= '0;
            pend_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_acc) begin
                beats_reg    <= tile_beats_i;
                val_cnt_reg  <= '0;
                exp_cnt_reg  <= '0;
                pack_cnt_reg <= '0;
                pend_reg     <= 1'b0;
            end else begin
                if (val_hs) begin
                    val_cnt_reg <= val_cnt_reg + CNT_W'(1);
                end
                if (exp_hs) begin
                    exp_cnt_reg  <= exp_cnt_reg + CNT_W'(1);
                    pack_cnt_reg <= pack_wrap ? '0 : pack_cnt_reg + PACK_W'(1);
                end else if (flush) begin
                    pack_cnt_reg <= '0;
                end
                if (pack_wrap || flush) begin
                    pend_reg <= 1'b1;
                end else if (word_ld) begin
                    pend_reg <= 1'b0;
                end
            end
        end
    end

    // One register per exponent lane; a lane is written when the pack pointer selects it.
    for (genvar gi = 0; gi < EXP_PER_WORD; gi++) begin : g_lane
        logic [EXP_W-1:0] lane_reg;

        always_ff @(posedge clk_i) begin
            if (rst_i || start_acc || word_ld) begin
                lane_reg <= '0;
            end else if (exp_hs && (pack_cnt_reg == PACK_W'(gi))) begin
                lane_reg <= exp_data_i;
            end
        end

        assign pack_word[gi*EXP_W +: EXP_W] = lane_reg;
    end

    // A pending exponent word takes priority over the next value beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_valid_reg <= 1'b0;
            wr_sel_reg   <= 1'b0;
            wr_data_reg  <= '0;
        end else if (ld) begin
            if (word_ld) begin
                wr_valid_reg <= 1'b1;
                wr_sel_reg   <= 1'b1;
                wr_data_reg  <= pack_word;
            end else if (val_hs) begin
                wr_valid_reg <= 1'b1;
                wr_sel_reg   <= 1'b0;
                wr_data_reg  <= val_data_i;
            end else begin
                wr_valid_reg <= 1'b0;
            end
        end
    end

`ifdef REDMULE_MX_WR_SCHED_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_exp_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc) begin
            perf_stall_reg <= '0;
            perf_exp_reg   <= '0;
        end else begin
            if (wr_valid_reg && !wr_ready_i && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (word_ld && (perf_exp_reg != '1)) begin
                perf_exp_reg <= perf_exp_reg + 32'd1;
            end
        end
    end

    assign perf_stall_o = perf_stall_reg;
    assign perf_exp_o   = perf_exp_reg;
`else
    assign perf_stall_o = '0;
    assign perf_exp_o   = '0;
`endif

endmodule

// File: tb/tb_redmule_mx_wr_scheduler.sv
// Self-checking bench for redmule_mx_wr_scheduler: table-driven tiles, random tiles and reset corner cases.
module tb_redmule_mx_wr_scheduler;
    localparam int DW    = 512;
    localparam int EW    = 8;
    localparam int CW    = 16;
    localparam int LANES = DW / EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] tile_beats;
    logic          val_valid;
    logic          val_ready;
    logic [DW-1:0] val_data;
    logic          exp_valid;
    logic          exp_ready;
    logic [EW-1:0] exp_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          wr_sel;
    logic          busy;
    logic          done;
    logic [31:0]   perf_stall;
    logic [31:0]   perf_exp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    redmule_mx_wr_scheduler #(.DATAW_ALIGN(DW), .EXP_W(EW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tile_beats_i(tile_beats),
        .val_valid_i(val_valid), .val_ready_o(val_ready), .val_data_i(val_data),
        .exp_valid_i(exp_valid), .exp_ready_o(exp_ready), .exp_data_i(exp_data),
        .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_data_o(wr_data), .wr_sel_o(wr_sel),
        .busy_o(busy), .done_o(done), .perf_stall_o(perf_stall), .perf_exp_o(perf_exp)
    );

    typedef struct {
        int n;
        int exp_first;
        int rmode;      // 0: all valid/ready, 1: random, 2: ready low for 5 cycles
        int restart;
        int beats;
        int words;
    } vec_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_valid"}, wr_valid, 0);
        check({tag, "_wr_sel"}, wr_sel, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_val_ready"}, val_ready, 0);
        check({tag, "_exp_ready"}, exp_ready, 0);
        check({tag, "_perf_stall"}, perf_stall, 0);
        check({tag, "_perf_exp"}, perf_exp, 0);
    endtask

    task automatic run_tile(input vec_t v);
        logic [DW-1:0] vals[$];
        logic [DW-1:0] words[$];
        logic [EW-1:0] exps[$];
        logic [DW-1:0] word;
        logic [DW-1:0] hdata;
        logic          hsel;
        logic [3:0]    sels;
        bit   hold, vh, eh, rand_valid;
        int   vi, ei, ob, ow_v, ow_w, dones, stalls, cyc, gap, done_cyc, wv_cycles;

        // Reference model: value beats in order, exponents packed 64 per word, zero-padded.
        for (int i = 0; i < v.n; i++) begin
            vals.push_back(rand_word());
            exps.push_back(EW'($urandom));
        end
        for (int w = 0; w * LANES < v.n; w++) begin
            word = '0;
            for (int l = 0; l < LANES && w * LANES + l < v.n; l++) word[l*EW +: EW] = exps[w*LANES + l];
            words.push_back(word);
        end

        vi = 0; ei = 0; ob = 0; ow_v = 0; ow_w = 0; dones = 0; stalls = 0;
        cyc = 0; gap = 0; done_cyc = -1; wv_cycles = 0; hold = 0; vh = 0; eh = 0;
        sels = '0; hdata = '0; hsel = 0;
        rand_valid = (v.rmode == 1);

        @(negedge clk);
        start = 1; tile_beats = CW'(v.n); val_valid = 0; exp_valid = 0; wr_ready = 1;
        @(negedge clk);
        while (dones == 0 && cyc < 3000) begin
            if (vh) begin val_valid = 0; vi++; end
            if (eh) begin exp_valid = 0; ei++; end
            if (ei == v.n) gap++;
            if (!val_valid && vi < v.n && (v.exp_first == 0 || gap >= 2)
                && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                val_valid = 1; val_data = vals[vi];
            end
            if (!exp_valid && ei < v.n && (!rand_valid || $urandom_range(0, 3) != 0)) begin
                exp_valid = 1; exp_data = exps[ei];
            end
            case (v.rmode)
                1:       wr_ready = ($urandom_range(0, 2) != 0);
                2:       wr_ready = !(cyc >= 10 && cyc < 15);
                default: wr_ready = 1;
            endcase
            start = (v.restart != 0 && cyc == 4);
            if (start) tile_beats = CW'(1);
            #1;
            vh = val_valid && val_ready;
            eh = exp_valid && exp_ready;
            if (cyc == 0) check("busy_in_tile", busy, 1);
            if (wr_valid) wv_cycles++;
            if (hold) begin
                check("hold_valid", wr_valid, 1);
                check("hold_data", wr_data, hdata);
                check("hold_sel", wr_sel, hsel);
            end
            if (wr_valid && !wr_ready) begin
                stalls++;
                check("stall_val_ready", val_ready, 0);
                hold = 1; hdata = wr_data; hsel = wr_sel;
            end else begin
                hold = 0;
            end
            if (wr_valid && wr_ready) begin
                if (ob < 4) sels[ob] = wr_sel;
                ob++;
                if (wr_sel == 1'b0) begin
                    if (ow_v < v.n) check("val_beat", wr_data, vals[ow_v]);
                    else begin checks++; errors++; $display("FAIL val_overrun: got beat %0d want at most %0d", ow_v + 1, v.n); end
                    ow_v++;
                end else begin
                    if (ow_w < words.size()) check("exp_word", wr_data, words[ow_w]);
                    else begin checks++; errors++; $display("FAIL word_overrun: got word %0d want at most %0d", ow_w + 1, words.size()); end
                    ow_w++;
                end
            end
            if (done) begin
                dones++; done_cyc = cyc;
                check("done_vals", ow_v, v.n);
                check("done_words", ow_w, words.size());
            end
            cyc++;
            if (dones == 0) @(negedge clk);
        end
        if (dones == 0) begin
            checks++; errors++;
            $display("FAIL tile_timeout: got no done after %0d cycles want done (n=%0d)", cyc, v.n);
        end

        @(negedge clk);
        val_valid = 0; exp_valid = 0; start = 0; wr_ready = 1;
        #1;
        check("done_single_pulse", done, 0);
        check("busy_after_done", busy, 0);
        check("tile_beats", ob, v.beats);
        check("tile_words", ow_w, v.words);
        if (v.n == 0) begin
            check("n0_done_latency", done_cyc, 1);
            check("n0_wr_valid_cycles", wv_cycles, 0);
        end
        if (v.n == 3 && v.rmode == 0) check("n3_sel_order", sels, 4'b1000);
        if (v.exp_first != 0 && v.n > 0) check("exp_first_word_leads", sels[0], 1);
        if (v.rmode == 2) check("stall_cycles", stalls, 5);
`ifdef REDMULE_MX_WR_SCHED_PERF_EN
        check("perf_stall", perf_stall, stalls);
        check("perf_exp", perf_exp, words.size());
`else
        check("perf_stall_tied", perf_stall, 0);
        check("perf_exp_tied", perf_exp, 0);
`endif
        $display("tile n=%0d exp_first=%0d rmode=%0d beats=%0d words=%0d stalls=%0d",
                 v.n, v.exp_first, v.rmode, ob, ow_w, stalls);
    endtask

    task automatic reset_mid_tile();
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1; tile_beats = CW'(8); wr_ready = 1;
        @(negedge clk);
        start = 0; val_valid = 1; exp_valid = 1;
        val_data = rand_word(); exp_data = EW'($urandom);
        for (int c = 0; c < 50 && seen < 2; c++) begin
            #1;
            if (wr_valid && wr_ready) seen++;
            if (seen < 2) begin
                @(negedge clk);
                val_data = rand_word(); exp_data = EW'($urandom);
            end
        end
        check("rst_mid_reached_beat2", seen, 2);
        rst = 1;
        @(posedge clk);
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 0; val_valid = 0; exp_valid = 0;
        $display("tile n=8 aborted by reset after %0d beats", seen);
    endtask

    initial begin
        vec_t tbl[9];
        vec_t rv;
        int   n;

        tbl[0] = '{n: 3,   exp_first: 0, rmode: 0, restart: 0, beats: 4,   words: 1};
        tbl[1] = '{n: 64,  exp_first: 1, rmode: 1, restart: 0, beats: 65,  words: 1};
        tbl[2] = '{n: 130, exp_first: 0, rmode: 1, restart: 0, beats: 133, words: 3};
        tbl[3] = '{n: 20,  exp_first: 0, rmode: 2, restart: 0, beats: 21,  words: 1};
        tbl[4] = '{n: 0,   exp_first: 0, rmode: 0, restart: 0, beats: 0,   words: 0};
        tbl[5] = '{n: 8,   exp_first: 0, rmode: 1, restart: 1, beats: 9,   words: 1};
        tbl[6] = '{n: 65,  exp_first: 1, rmode: 1, restart: 0, beats: 67,  words: 2};
        tbl[7] = '{n: 128, exp_first: 0, rmode: 1, restart: 0, beats: 130, words: 2};
        tbl[8] = '{n: 1,   exp_first: 0, rmode: 0, restart: 0, beats: 2,   words: 1};

        rst = 1; start = 0; tile_beats = '0; val_valid = 0; val_data = '0;
        exp_valid = 0; exp_data = '0; wr_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check_all_zero("reset");

        for (int i = 0; i < 9; i++) run_tile(tbl[i]);

        reset_mid_tile();
        run_tile(tbl[0]);

        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(1, 200);
            rv = '{n: n, exp_first: int'($urandom_range(0, 1)), rmode: 1, restart: 0,
                   beats: n + (n + LANES - 1) / LANES, words: (n + LANES - 1) / LANES};
            run_tile(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "global timeout");
    end
endmodule
